// File: rtl/dmem_responder.sv
// dmem_responder
// Memory-side end of the load/store path. Accepts one word-aligned request
// at a time, waits WAIT_CYCLES extra cycles, commits a byte-lane-masked store
// or a whole-word load against an internal word array, then presents a
// response that is held until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  request present            req_ready  block can accept a request
//   req_addr   byte address ([1:0] unused) req_we     1 = store, 0 = load
//   req_wstrb  byte-lane write enables     req_wdata  lane-placed store data
//   rsp_valid  response present           rsp_ready  consumer accepts response
//   rsp_rdata  loaded word (0 for stores and errors)
//   rsp_err    address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS)
module dmem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_32 = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t        state_r, state_nxt_s;
    logic [3:0]    cnt_r, cnt_nxt_s;
    logic [AW-1:0] idx_r;
    logic          we_r;
    logic [3:0]    wstrb_r;
    logic [31:0]   wdata_r;
    logic          oor_r;

    logic          capture_s;
    logic          commit_s;
    logic          req_ready_nxt_s;
    logic          rsp_valid_nxt_s;
    logic [31:0]   rsp_rdata_nxt_s;
    logic          rsp_err_nxt_s;

    // Word index is formed in 32 bits so an address below BASE_ADDR wraps to
    // a huge index and falls out of range instead of aliasing into the array.
    logic [31:0] offset_s;
    logic [31:0] word_idx_s;
    logic        in_range_s;

    assign offset_s   = req_addr - BASE_ADDR;
    assign word_idx_s = offset_s >> 2'd2;
    assign in_range_s = (word_idx_s < DEPTH_32);

    // State, wait counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            req_ready <= req_ready_nxt_s;
            rsp_valid <= rsp_valid_nxt_s;
            rsp_rdata <= rsp_rdata_nxt_s;
            rsp_err   <= rsp_err_nxt_s;
        end
    end

    // Request capture; the inputs are only looked at on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r   <= '0;
            we_r    <= 1'b0;
            wstrb_r <= 4'd0;
            wdata_r <= 32'd0;
            oor_r   <= 1'b0;
        end else if (capture_s) begin
            idx_r   <= word_idx_s[AW-1:0];
            we_r    <= req_we;
            wstrb_r <= req_wstrb;
            wdata_r <= req_wdata;
            oor_r   <= ~in_range_s;
        end else begin
            idx_r   <= idx_r;
        end
    end

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_r[i]) begin
                    mem[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
                end
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        capture_s       = 1'b0;
        commit_s        = 1'b0;
        req_ready_nxt_s = req_ready;
        rsp_valid_nxt_s = rsp_valid;
        rsp_rdata_nxt_s = rsp_rdata;
        rsp_err_nxt_s   = rsp_err;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    capture_s       = 1'b1;
                    req_ready_nxt_s = 1'b0;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt_s = S_WAIT;
                        cnt_nxt_s   = 4'(WAIT_CYCLES - 1);
                    end else begin
                        state_nxt_s = S_ACCESS;
                    end
                end else begin
                    req_ready_nxt_s = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = S_ACCESS;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            S_ACCESS: begin
                state_nxt_s     = S_RESP;
                rsp_valid_nxt_s = 1'b1;
                if (oor_r) begin
                    rsp_err_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s = 32'd0;
                end else if (we_r) begin
                    commit_s        = 1'b1;
                    rsp_err_nxt_s   = 1'b0;
                    rsp_rdata_nxt_s = 32'd0;
                end else begin
                    rsp_err_nxt_s   = 1'b0;
                    rsp_rdata_nxt_s = mem[idx_r];
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s     = S_IDLE;
                    rsp_valid_nxt_s = 1'b0;
                    req_ready_nxt_s = 1'b1;
                end else begin
                    rsp_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s     = S_IDLE;
                req_ready_nxt_s = 1'b1;
                rsp_valid_nxt_s = 1'b0;
            end
        endcase
    end

endmodule
